lamp_fpu_div_ctrl: RTL and testbench



---
 rtl/lampFPU_pkg.sv | 37 +++
 rtl/lamp_fpu_bf16_unpack.sv | 38 +++
 rtl/lamp_fpu_div_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_lamp_fpu_div_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lampFPU_pkg.sv
// Shared types and constants for the bf16 LAMP divider front end.
package lampFPU_pkg;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [15:0] CANON_QNAN_BF16 = 16'h7FC0;
  localparam logic [15:0] INF_BF16        = 16'h7F80;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RND   = 3'd3,
    OUT   = 3'd4
  } div_state_e;

  // One unpacked, classified bf16 operand as the divider consumes it.
  typedef struct packed {
    logic       s;
    logic [7:0] ext_sh_f;
    logic [8:0] ext_e;
    logic [2:0] nlz;
    logic       is_z;
    logic       is_inf;
    logic       is_snan;
    logic       is_qnan;
  } lamp_op_t;

  function automatic logic is_special(input lamp_op_t op);
    return op.is_z | op.is_inf | op.is_snan | op.is_qnan;
  endfunction

endpackage

// File: rtl/lamp_fpu_bf16_unpack.sv
// Combinational bf16 unpack: classify, count leading zeros, normalize significand.
module lamp_fpu_bf16_unpack
  import lampFPU_pkg::*;
(
  input  logic [15:0] op_i,
  output lamp_op_t    op_o
);

  logic [7:0] exp_f;
  logic [6:0] frac_f;
  logic [7:0] ext_f;
  logic [2:0] nlz;

  assign exp_f  = op_i[14:7];
  assign frac_f = op_i[6:0];
  assign ext_f  = {exp_f != 8'd0, frac_f};

  // Scanning upward, the last set bit seen is the MSB one; all-zero leaves nlz at 0.
  always_comb begin
    nlz = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (ext_f[i]) nlz = 3'(7 - i);
    end
  end

  always_comb begin
    op_o          = '0;
    op_o.s        = op_i[15];
    op_o.nlz      = nlz;
    op_o.ext_sh_f = ext_f << nlz;
    op_o.ext_e    = {1'b0, (exp_f == 8'd0) ? 8'd1 : exp_f};
    op_o.is_z     = (exp_f == 8'd0) && (frac_f == 7'd0);
    op_o.is_inf   = (exp_f == 8'hFF) && (frac_f == 7'd0);
    op_o.is_qnan  = (exp_f == 8'hFF) && frac_f[6];
    op_o.is_snan  = (exp_f == 8'hFF) && (frac_f != 7'd0) && !frac_f[6];
  end

endmodule

// File: rtl/lamp_fpu_div_ctrl.sv
// Issue/retire controller for the bf16 LAMP divider: unpack, launch, round, pack.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high. Input side: in_ready_o is high only in IDLE. Output side: once
// out_valid_o rises, res_o/flags_o hold until out_ready_i completes the transfer.
module lamp_fpu_div_ctrl
  import lampFPU_pkg::*;
#(
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [15:0] op1_i,
  input  logic [15:0] op2_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [15:0] res_o,
  output logic [4:0]  flags_o,
  output logic        doDiv_o,
  output logic        s_op1_o,
  output logic [7:0]  extShF_op1_o,
  output logic [8:0]  extE_op1_o,
  output logic [2:0]  nlz_op1_o,
  output logic        isZ_op1_o,
  output logic        isInf_op1_o,
  output logic        isSNAN_op1_o,
  output logic        isQNAN_op1_o,
  output logic        s_op2_o,
  output logic [7:0]  extShF_op2_o,
  output logic [8:0]  extE_op2_o,
  output logic [2:0]  nlz_op2_o,
  output logic        isZ_op2_o,
  output logic        isInf_op2_o,
  output logic        isSNAN_op2_o,
  output logic        isQNAN_op2_o,
  input  logic        div_s_i,
  input  logic [7:0]  div_e_i,
  input  logic [11:0] div_f_i,
  input  logic        div_valid_i,
  input  logic        div_ovf_i,
  input  logic        div_unf_i,
  input  logic        div_toRound_i,
  output div_state_e  dbg_state_o
);

  div_state_e  state_q, state_d;
  logic        started_q;
  lamp_op_t    op1_un, op2_un, op1_q, op2_q;
  logic        in_special;
  logic        accept;

  logic        div_s_q;
  logic [7:0]  div_e_q;
  logic [9:0]  div_f_q;
  logic        div_ovf_q, div_unf_q, div_rnd_q;

  logic [15:0] res_q, res_d;
  logic [4:0]  flags_q, flags_d;
  logic        rnd_up;
  logic [15:0] rnd_sum;
  logic        grs;
  logic        sign_sp;
  logic        any_nan, zz, ii;

  // Overflow and hidden bits travel separately as div_ovf_i and the exponent.
  logic        unused_div_bits;
  assign unused_div_bits = ^div_f_i[11:10];

  lamp_fpu_bf16_unpack u_unpack_op1 (.op_i(op1_i), .op_o(op1_un));
  lamp_fpu_bf16_unpack u_unpack_op2 (.op_i(op2_i), .op_o(op2_un));

  assign in_special = is_special(op1_un) | is_special(op2_un);
  assign in_ready_o = (state_q == IDLE) && started_q;
  assign accept     = in_valid_i && in_ready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (FAST_SPECIAL && in_special) ? RND : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (div_valid_i) state_d = RND;
      RND:     state_d = OUT;
      OUT:     if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand fields stay put from acceptance until the next acceptance, which
  // covers the window in which the divider samples them.
  always_ff @(posedge clk) begin
    if (rst) begin
      op1_q     <= '0;
      op2_q     <= '0;
      div_s_q   <= 1'b0;
      div_e_q   <= '0;
      div_f_q   <= '0;
      div_ovf_q <= 1'b0;
      div_unf_q <= 1'b0;
      div_rnd_q <= 1'b0;
      res_q     <= '0;
      flags_q   <= '0;
    end else begin
      if (accept) begin
        op1_q <= op1_un;
        op2_q <= op2_un;
      end
      if (state_q == WAIT && div_valid_i) begin
        div_s_q   <= div_s_i;
        div_e_q   <= div_e_i;
        div_f_q   <= div_f_i[9:0];
        div_ovf_q <= div_ovf_i;
        div_unf_q <= div_unf_i;
        div_rnd_q <= div_toRound_i;
      end
      if (state_q == RND) begin
        res_q   <= res_d;
        flags_q <= flags_d;
      end
    end
  end

  assign sign_sp = op1_q.s ^ op2_q.s;
  assign any_nan = op1_q.is_snan | op1_q.is_qnan | op2_q.is_snan | op2_q.is_qnan;
  assign zz      = op1_q.is_z & op2_q.is_z;
  assign ii      = op1_q.is_inf & op2_q.is_inf;
  assign grs     = |div_f_q[2:0];

  always_comb begin
    res_d   = '0;
    flags_d = '0;
    rnd_up  = 1'b0;
    rnd_sum = '0;
    if (is_special(op1_q) || is_special(op2_q)) begin
      if (any_nan || zz || ii) begin
        res_d            = CANON_QNAN_BF16;
        flags_d[FLAG_NV] = op1_q.is_snan | op2_q.is_snan | zz | ii;
      end else if (op1_q.is_inf) begin
        res_d = {sign_sp, INF_BF16[14:0]};
      end else if (op2_q.is_z) begin
        res_d            = {sign_sp, INF_BF16[14:0]};
        flags_d[FLAG_DZ] = 1'b1;
      end else begin
        res_d = {sign_sp, 15'd0};
      end
    end else if (div_rnd_q) begin
      // Round to nearest, ties to even on the LSB of the 7-bit fraction.
      rnd_up  = div_f_q[2] & (div_f_q[3] | div_f_q[1] | div_f_q[0]);
      rnd_sum = {1'b0, div_e_q, div_f_q[9:3]} + {15'd0, rnd_up};
      if (div_ovf_q || rnd_sum[15] || rnd_sum[14:7] == 8'hFF) begin
        res_d            = {div_s_q, INF_BF16[14:0]};
        flags_d[FLAG_OF] = 1'b1;
        flags_d[FLAG_NX] = 1'b1;
      end else begin
        res_d            = {div_s_q, rnd_sum[14:0]};
        flags_d[FLAG_NX] = grs;
        flags_d[FLAG_UF] = div_unf_q & grs;
      end
    end else begin
      res_d = {div_s_q, div_e_q, div_f_q[9:3]};
      if (div_e_q == 8'hFF && div_f_q[9:3] != 7'd0) res_d = CANON_QNAN_BF16;
    end
  end

  assign out_valid_o  = (state_q == OUT);
  assign doDiv_o      = (state_q == ISSUE);
  assign res_o        = res_q;
  assign flags_o      = flags_q;
  assign dbg_state_o  = state_q;

  assign s_op1_o      = op1_q.s;
  assign extShF_op1_o = op1_q.ext_sh_f;
  assign extE_op1_o   = op1_q.ext_e;
  assign nlz_op1_o    = op1_q.nlz;
  assign isZ_op1_o    = op1_q.is_z;
  assign isInf_op1_o  = op1_q.is_inf;
  assign isSNAN_op1_o = op1_q.is_snan;
  assign isQNAN_op1_o = op1_q.is_qnan;
  assign s_op2_o      = op2_q.s;
  assign extShF_op2_o = op2_q.ext_sh_f;
  assign extE_op2_o   = op2_q.ext_e;
  assign nlz_op2_o    = op2_q.nlz;
  assign isZ_op2_o    = op2_q.is_z;
  assign isInf_op2_o  = op2_q.is_inf;
  assign isSNAN_op2_o = op2_q.is_snan;
  assign isQNAN_op2_o = op2_q.is_qnan;

endmodule

// File: tb/tb_lamp_fpu_div_ctrl.sv
// Directed bench for lamp_fpu_div_ctrl; the bench plays the divider with hand-built results.
module tb_lamp_fpu_div_ctrl;
  import lampFPU_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [15:0] op1_i = '0;
  logic [15:0] op2_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [15:0] res_o;
  logic [4:0]  flags_o;
  logic        doDiv_o;
  logic        s_op1_o, s_op2_o;
  logic [7:0]  extShF_op1_o, extShF_op2_o;
  logic [8:0]  extE_op1_o, extE_op2_o;
  logic [2:0]  nlz_op1_o, nlz_op2_o;
  logic        isZ_op1_o, isInf_op1_o, isSNAN_op1_o, isQNAN_op1_o;
  logic        isZ_op2_o, isInf_op2_o, isSNAN_op2_o, isQNAN_op2_o;
  logic        div_s_i = 1'b0;
  logic [7:0]  div_e_i = '0;
  logic [11:0] div_f_i = '0;
  logic        div_valid_i = 1'b0;
  logic        div_ovf_i = 1'b0;
  logic        div_unf_i = 1'b0;
  logic        div_toRound_i = 1'b0;
  div_state_e  dbg_state_o;

  int n_vec = 0;
  int n_bad = 0;
  int dodiv_cnt = 0;
  logic [20:0] exp_q[$];

  lamp_fpu_div_ctrl #(.FAST_SPECIAL(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op1_i(op1_i), .op2_i(op2_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .res_o(res_o), .flags_o(flags_o), .doDiv_o(doDiv_o),
    .s_op1_o(s_op1_o), .extShF_op1_o(extShF_op1_o), .extE_op1_o(extE_op1_o),
    .nlz_op1_o(nlz_op1_o), .isZ_op1_o(isZ_op1_o), .isInf_op1_o(isInf_op1_o),
    .isSNAN_op1_o(isSNAN_op1_o), .isQNAN_op1_o(isQNAN_op1_o),
    .s_op2_o(s_op2_o), .extShF_op2_o(extShF_op2_o), .extE_op2_o(extE_op2_o),
    .nlz_op2_o(nlz_op2_o), .isZ_op2_o(isZ_op2_o), .isInf_op2_o(isInf_op2_o),
    .isSNAN_op2_o(isSNAN_op2_o), .isQNAN_op2_o(isQNAN_op2_o),
    .div_s_i(div_s_i), .div_e_i(div_e_i), .div_f_i(div_f_i),
    .div_valid_i(div_valid_i), .div_ovf_i(div_ovf_i), .div_unf_i(div_unf_i),
    .div_toRound_i(div_toRound_i),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && doDiv_o) dodiv_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver: present an operand pair and hold it until accepted
  task automatic accept(input string tag, input logic [15:0] a, input logic [15:0] b);
    int n;
    n = 0;
    while (!in_ready_o && n < 20) begin
      step();
      n++;
    end
    check({tag, ":in_ready"}, 32'(in_ready_o), 32'd1);
    op1_i = a;
    op2_i = b;
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
  endtask

  // driver: play the divider (or expect bypass), then check the retired result
  task automatic complete(input string tag, input bit bypass,
                          input logic ds, input logic [7:0] de, input logic [11:0] df,
                          input logic ovf, input logic unf, input logic tr,
                          input logic [15:0] er, input logic [4:0] ef, input bit hs);
    int cnt0;
    logic [20:0] exp_item;
    cnt0 = dodiv_cnt;
    exp_q.push_back({ef, er});
    if (!bypass) begin
      check({tag, ":dodiv_hi"}, 32'(doDiv_o), 32'd1);
      step();
      check({tag, ":dodiv_lo"}, 32'(doDiv_o), 32'd0);
      step();
      step();
      div_s_i = ds; div_e_i = de; div_f_i = df;
      div_ovf_i = ovf; div_unf_i = unf; div_toRound_i = tr;
      div_valid_i = 1'b1;
      step();
      div_valid_i = 1'b0;
      check({tag, ":early_valid"}, 32'(out_valid_o), 32'd0);
      step();
      check({tag, ":dodiv_pulses"}, 32'(dodiv_cnt - cnt0), 32'd1);
    end else begin
      check({tag, ":early_valid"}, 32'(out_valid_o), 32'd0);
      step();
      check({tag, ":no_dodiv"}, 32'(dodiv_cnt - cnt0), 32'd0);
    end
    check({tag, ":out_valid"}, 32'(out_valid_o), 32'd1);
    exp_item = exp_q.pop_front();
    check({tag, ":res"}, 32'(res_o), 32'(exp_item[15:0]));
    check({tag, ":flags"}, 32'(flags_o), 32'(exp_item[20:16]));
    if (hs) begin
      out_ready_i = 1'b1;
      step();
      out_ready_i = 1'b0;
      check({tag, ":out_drop"}, 32'(out_valid_o), 32'd0);
    end
  endtask

  initial begin
    step();
    step();
    check("rst:in_ready", 32'(in_ready_o), 32'd0);
    check("rst:out_valid", 32'(out_valid_o), 32'd0);
    check("rst:res", 32'(res_o), 32'd0);
    check("rst:flags", 32'(flags_o), 32'd0);
    check("rst:dodiv", 32'(doDiv_o), 32'd0);
    check("rst:extE1", 32'(extE_op1_o), 32'd0);
    check("rst:state", 32'(dbg_state_o), 32'(IDLE));
    rst = 1'b0;
    check("rst:ready_late", 32'(in_ready_o), 32'd0);
    step();
    check("rst:ready_rise", 32'(in_ready_o), 32'd1);

    // 1/2: exact
    accept("half", 16'h3F80, 16'h4000);
    check("half:extShF1", 32'(extShF_op1_o), 32'h80);
    check("half:extE1", 32'(extE_op1_o), 32'h07F);
    check("half:extE2", 32'(extE_op2_o), 32'h080);
    check("half:nlz1", 32'(nlz_op1_o), 32'd0);
    complete("half", 1'b0, 1'b0, 8'h7E, 12'h400, 1'b0, 1'b0, 1'b1, 16'h3F00, 5'b00000, 1'b1);

    // 1/3: G=1, S=1 rounds up
    accept("third", 16'h3F80, 16'h4040);
    check("third:extShF2", 32'(extShF_op2_o), 32'hC0);
    complete("third", 1'b0, 1'b0, 8'h7D, 12'h555, 1'b0, 1'b0, 1'b1, 16'h3EAB, 5'b00001, 1'b1);

    // max / 0.25 overflows
    accept("ovf", 16'h7F7F, 16'h3E80);
    complete("ovf", 1'b0, 1'b0, 8'h00, 12'h7F8, 1'b1, 1'b0, 1'b1, 16'h7F80, 5'b00101, 1'b1);

    // rounding carry ripples into exponent FF
    accept("carry", 16'hFF7F, 16'h3F7F);
    complete("carry", 1'b0, 1'b1, 8'hFE, 12'h7FE, 1'b0, 1'b0, 1'b1, 16'hFF80, 5'b00101, 1'b1);

    // exact tie, even LSB stays
    accept("tie_dn", 16'h3F80, 16'h3F80);
    complete("tie_dn", 1'b0, 1'b0, 8'h7F, 12'h404, 1'b0, 1'b0, 1'b1, 16'h3F80, 5'b00001, 1'b1);

    // exact tie, odd LSB rounds to even
    accept("tie_up", 16'h3F82, 16'h3F80);
    complete("tie_up", 1'b0, 1'b0, 8'h7F, 12'h40C, 1'b0, 1'b0, 1'b1, 16'h3F82, 5'b00001, 1'b1);

    // tiny inexact result sets UF
    accept("unf", 16'h0080, 16'h4000);
    complete("unf", 1'b0, 1'b0, 8'h00, 12'h202, 1'b0, 1'b1, 1'b1, 16'h0040, 5'b00011, 1'b1);

    // unrounded passthrough and NaN canonicalisation
    accept("noround", 16'h4080, 16'h4000);
    complete("noround", 1'b0, 1'b0, 8'h80, 12'h500, 1'b0, 1'b0, 1'b0, 16'h4020, 5'b00000, 1'b1);
    accept("nr_nan", 16'h4080, 16'h4000);
    complete("nr_nan", 1'b0, 1'b1, 8'hFF, 12'h408, 1'b0, 1'b0, 1'b0, 16'h7FC0, 5'b00000, 1'b1);

    // bypassed specials
    accept("dz", 16'h3F80, 16'h0000);
    check("dz:isZ2", 32'(isZ_op2_o), 32'd1);
    check("dz:extE2", 32'(extE_op2_o), 32'd1);
    complete("dz", 1'b1, 1'b0, 8'h00, 12'h000, 1'b0, 1'b0, 1'b0, 16'h7F80, 5'b01000, 1'b1);
    accept("zz", 16'h0000, 16'h0000);
    complete("zz", 1'b1, 1'b0, 8'h00, 12'h000, 1'b0, 1'b0, 1'b0, 16'h7FC0, 5'b10000, 1'b1);
    accept("snan", 16'h0005, 16'h7F81);
    check("snan:extShF1", 32'(extShF_op1_o), 32'hA0);
    check("snan:nlz1", 32'(nlz_op1_o), 32'd5);
    check("snan:extE1", 32'(extE_op1_o), 32'd1);
    check("snan:isSNAN2", 32'(isSNAN_op2_o), 32'd1);
    check("snan:isQNAN2", 32'(isQNAN_op2_o), 32'd0);
    complete("snan", 1'b1, 1'b0, 8'h00, 12'h000, 1'b0, 1'b0, 1'b0, 16'h7FC0, 5'b10000, 1'b1);
    accept("qnan", 16'hFFC0, 16'h3F80);
    check("qnan:isQNAN1", 32'(isQNAN_op1_o), 32'd1);
    check("qnan:s1", 32'(s_op1_o), 32'd1);
    complete("qnan", 1'b1, 1'b0, 8'h00, 12'h000, 1'b0, 1'b0, 1'b0, 16'h7FC0, 5'b00000, 1'b1);
    accept("ii", 16'h7F80, 16'hFF80);
    check("ii:isInf1", 32'(isInf_op1_o), 32'd1);
    complete("ii", 1'b1, 1'b0, 8'h00, 12'h000, 1'b0, 1'b0, 1'b0, 16'h7FC0, 5'b10000, 1'b1);
    accept("inf_fin", 16'hFF80, 16'h3F80);
    complete("inf_fin", 1'b1, 1'b0, 8'h00, 12'h000, 1'b0, 1'b0, 1'b0, 16'hFF80, 5'b00000, 1'b1);
    accept("inf_z", 16'h7F80, 16'h0000);
    complete("inf_z", 1'b1, 1'b0, 8'h00, 12'h000, 1'b0, 1'b0, 1'b0, 16'h7F80, 5'b00000, 1'b1);
    accept("z_fin", 16'h8000, 16'h3F80);
    complete("z_fin", 1'b1, 1'b0, 8'h00, 12'h000, 1'b0, 1'b0, 1'b0, 16'h8000, 5'b00000, 1'b1);
    accept("fin_inf", 16'h3F80, 16'hFF80);
    complete("fin_inf", 1'b1, 1'b0, 8'h00, 12'h000, 1'b0, 1'b0, 1'b0, 16'h8000, 5'b00000, 1'b1);

    // backpressure with a second pair waiting
    accept("bp", 16'h3F80, 16'h4000);
    complete("bp", 1'b0, 1'b0, 8'h7E, 12'h400, 1'b0, 1'b0, 1'b1, 16'h3F00, 5'b00000, 1'b0);
    op1_i = 16'h3F80;
    op2_i = 16'h0000;
    in_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp:hold_res", 32'(res_o), 32'h3F00);
      check("bp:hold_valid", 32'(out_valid_o), 32'd1);
      check("bp:hold_ready", 32'(in_ready_o), 32'd0);
    end
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    check("bp:hs_done", 32'(out_valid_o), 32'd0);
    check("bp:ready_back", 32'(in_ready_o), 32'd1);
    step();
    in_valid_i = 1'b0;
    check("bp:second_taken", 32'(in_ready_o), 32'd0);
    step();
    check("bp:second_valid", 32'(out_valid_o), 32'd1);
    check("bp:second_res", 32'(res_o), 32'h7F80);
    check("bp:second_flags", 32'(flags_o), 32'b01000);
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;

    // reset while waiting on the divider, then a stray divider pulse
    accept("abort", 16'h3F80, 16'h4040);
    step();
    check("abort:in_wait", 32'(dbg_state_o), 32'(WAIT));
    rst = 1'b1;
    step();
    step();
    check("abort:state", 32'(dbg_state_o), 32'(IDLE));
    check("abort:in_ready", 32'(in_ready_o), 32'd0);
    check("abort:res", 32'(res_o), 32'd0);
    check("abort:flags", 32'(flags_o), 32'd0);
    check("abort:extShF1", 32'(extShF_op1_o), 32'd0);
    check("abort:dodiv", 32'(doDiv_o), 32'd0);
    rst = 1'b0;
    div_s_i = 1'b0; div_e_i = 8'h7D; div_f_i = 12'h555;
    div_toRound_i = 1'b1; div_valid_i = 1'b1;
    step();
    div_valid_i = 1'b0;
    check("abort:stray_state", 32'(dbg_state_o), 32'(IDLE));
    check("abort:ready_rise", 32'(in_ready_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort:no_out", 32'(out_valid_o), 32'd0);
    end
    check("sb:drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
